// File: rtl/sensor_priority_arbiter_if.sv
// Request/thermal inputs and actuator/display outputs of the sensor priority arbiter.
interface sensor_priority_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned TEMP_W = 6
);
  localparam int unsigned N_CH  = N_REQ + 2;
  localparam int unsigned IDX_W = $clog2(N_CH + 1);

  logic [N_REQ-1:0]  req;
  logic              ST;
  logic [TEMP_W-1:0] temperature;
  logic [N_CH-1:0]   grant;
  logic [IDX_W-1:0]  display;
  logic              reversed_priority;

  modport master (
    output req, ST, temperature,
    input  grant, display, reversed_priority
  );

  modport slave (
    input  req, ST, temperature,
    output grant, display, reversed_priority
  );
endinterface

// File: rtl/sensor_priority_arbiter.sv
// Priority arbiter over door/alarm/window requests plus heater/cooler thermal channels.
// Optional minimum grant hold enabled by SENSOR_PRIORITY_ARBITER_MIN_HOLD_EN.
module sensor_priority_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TEMP_W   = 6,
  parameter int unsigned T_LOW    = 8,
  parameter int unsigned T_HIGH   = 30,
  parameter int unsigned HYST     = 2,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned MIN_HOLD = 4
) (
  input logic clk,
  input logic reset,
  sensor_priority_arbiter_if.slave bus
);
  localparam int unsigned N_CH  = N_REQ + 2;
  localparam int unsigned IDX_W = $clog2(N_CH + 1);

  // Thresholds widened by one bit so T_LOW+HYST cannot overflow the temperature range
  localparam logic [TEMP_W:0] HEAT_ON  = (TEMP_W+1)'(T_LOW);
  localparam logic [TEMP_W:0] HEAT_OFF = (TEMP_W+1)'(T_LOW + HYST);
  localparam logic [TEMP_W:0] COOL_ON  = (TEMP_W+1)'(T_HIGH);
  localparam logic [TEMP_W:0] COOL_OFF = (TEMP_W+1)'(T_HIGH - HYST);

  logic             heat_q, heat_d;
  logic             cool_q, cool_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] disp_q, disp_d;

  logic [TEMP_W:0]  temp_x;
  logic [N_CH-1:0]  act;
  logic             act_any;
  logic             rev;
  logic [IDX_W-1:0] win_disp;
  logic [N_CH-1:0]  win_grant;

`ifdef SENSOR_PRIORITY_ARBITER_MIN_HOLD_EN
  localparam int unsigned HOLD_W = $clog2(MIN_HOLD) + 1;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              keep;
`endif

  assign temp_x  = {1'b0, bus.temperature};
  assign act     = {cool_q, heat_q, bus.req};
  assign act_any = |act;
  assign rev     = cnt_q[CNT_W-1];

  // Winner as display code (index+1); scan order picks lowest or highest active channel
  always_comb begin
    win_disp = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (rev) begin
        if (act[i]) win_disp = IDX_W'(i + 1);
      end else begin
        if (act[int'(N_CH) - 1 - i]) win_disp = IDX_W'(int'(N_CH) - i);
      end
    end
    for (int i = 0; i < int'(N_CH); i++) begin
      win_grant[i] = (win_disp == IDX_W'(i + 1));
    end
  end

  always_comb begin
    heat_d  = heat_q;
    cool_d  = cool_q;
    cnt_d   = cnt_q;
    grant_d = win_grant;
    disp_d  = win_disp;

    if (bus.ST && temp_x <= HEAT_ON)        heat_d = 1'b1;
    else if (!bus.ST || temp_x >= HEAT_OFF) heat_d = 1'b0;

    if (bus.ST && temp_x >= COOL_ON)        cool_d = 1'b1;
    else if (!bus.ST || temp_x <= COOL_OFF) cool_d = 1'b0;

    if (act_any) cnt_d = cnt_q + 1'b1;

`ifdef SENSOR_PRIORITY_ARBITER_MIN_HOLD_EN
    // Current grant survives while its hold runs and its channel stays active
    keep   = (hold_q != '0) && (|(grant_q & act));
    hold_d = hold_q;
    if (!act_any) begin
      hold_d = '0;
    end else if (keep) begin
      grant_d = grant_q;
      disp_d  = disp_q;
      hold_d  = hold_q - 1'b1;
    end else if (win_disp != disp_q) begin
      hold_d  = HOLD_W'(MIN_HOLD - 1);
    end else begin
      hold_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      heat_q  <= 1'b0;
      cool_q  <= 1'b0;
      cnt_q   <= '0;
      grant_q <= '0;
      disp_q  <= '0;
`ifdef SENSOR_PRIORITY_ARBITER_MIN_HOLD_EN
      hold_q  <= '0;
`endif
    end else begin
      heat_q  <= heat_d;
      cool_q  <= cool_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      disp_q  <= disp_d;
`ifdef SENSOR_PRIORITY_ARBITER_MIN_HOLD_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign bus.grant             = grant_q;
  assign bus.display           = disp_q;
  assign bus.reversed_priority = rev;
endmodule

// File: doc/sensor_priority_arbiter.md
SENSOR_PRIORITY_ARBITER -- requirements
Module: sensor_priority_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of binary request channels (channel 0 front door, 1 rear door, 2 alarm, 3 window).
REQ-002 Parameter TEMP_W, default 6, temperature width, unsigned.
REQ-003 Parameter T_LOW, default 8; T_HIGH, default 30; HYST, default 2: thermal thresholds and hysteresis.
REQ-004 Parameter CNT_W, default 4, priority-reversal counter width.
REQ-005 Parameter MIN_HOLD, default 4, minimum grant duration in cycles, >=1.
REQ-006 Derived: N_CH = N_REQ+2 (channel N_REQ heater, N_REQ+1 cooler); IDX_W = clog2(N_CH+1).
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 req  input  N_REQ  per-channel request, level.
REQ-010 ST  input  1  thermal sensing enable.
REQ-011 temperature  input  TEMP_W  current temperature.
REQ-012 grant  output  N_CH  registered one-hot actuator enable, all-zero when idle.
REQ-013 display  output  IDX_W  registered granted channel index+1, 0 when idle.
REQ-014 reversed_priority  output  1  current priority direction, MSB of reversal counter.

Function
REQ-015 Thermal flags heat_act/cool_act SHALL be registered: heat_act sets when ST && temperature<=T_LOW, clears when !ST || temperature>=T_LOW+HYST, else holds.
REQ-016 cool_act sets when ST && temperature>=T_HIGH, clears when !ST || temperature<=T_HIGH-HYST, else holds.
REQ-017 Active vector act = {cool_act, heat_act, req}.
REQ-018 Reversal counter SHALL increment by 1 every cycle act!=0, hold when act==0, wrap 2^CNT_W-1 -> 0.
REQ-019 Normal priority (reversed_priority=0): lowest active index wins; reversed: highest active index wins.
REQ-020 Arbitration result SHALL be registered: req change at edge n -> grant/display at edge n+1; temperature change -> edge n+2.
REQ-021 grant SHALL be one-hot or zero; display SHALL equal granted index+1 in the same cycle.
REQ-022 On a grant change to channel c, hold counter SHALL load MIN_HOLD-1.
REQ-023 While hold counter>0 and act[c]=1, grant SHALL remain c (no preemption, even by higher priority or a reversal toggle); counter decrements each cycle.
REQ-024 If act[c] drops during hold, hold SHALL abort and arbitration resumes next edge.
REQ-025 When hold counter==0, normal arbitration each cycle; re-winning c does not reload the counter.
REQ-026 act==0 -> grant=0, display=0 next edge, hold counter cleared.

Reset
REQ-027 reset low SHALL asynchronously clear grant, display, reversal counter, hold counter, heat_act, cool_act.
REQ-028 First arbitration after reset deassertion SHALL occur at the first rising clk edge with reset high.
REQ-029 Reset asserted mid-hold SHALL abandon the hold with no residual state.

Configuration
REQ-030 Macro SENSOR_PRIORITY_ARBITER_MIN_HOLD_EN: defined -> REQ-022..REQ-025 hold behaviour; undefined -> no hold counter, arbitration every cycle, MIN_HOLD ignored.

Verification (defaults, macro defined unless noted)
REQ-031 req=4'b0101 from reset, counter 0 -> grant=6'b000001, display=1 after 1 edge; counter reaches 8 after 8 active cycles -> grant switches to channel 2 (display=3) once hold expired.
REQ-032 Grant ch3 (display=4), then req[0] asserted next cycle -> grant stays ch3 for 4 cycles total, then ch0 (display=1).
REQ-033 ST=1, temperature 8 -> heater grant (display=5) after 2 edges; temperature 9 keeps it; temperature 10 -> released.
REQ-034 ST=1, temperature 30 -> cooler (display=6); 29 holds; 28 releases; ST=0 at any temperature releases within 2 edges.
REQ-035 reset pulsed low mid-hold at counter 7 -> grant=0, display=0, reversed_priority=0 immediately, no clk needed.
REQ-036 Macro undefined: grant ch3 then req[0] asserted -> grant ch0 on next edge.
